// File: rtl/wb_port_arbiter_pkg.sv
// Types shared by the regfile write-port arbiter and its pending queue.
`include "defines.vh"

package wb_port_arbiter_pkg;

    typedef logic [`W_REGF-1:0] regf_t;
    typedef logic [`W_DATA-1:0] data_t;

    localparam regf_t REGF_ZERO = `REGF_ZERO;

    // One queued late result.
    typedef struct packed {
        regf_t regf;
        data_t data;
    } pend_entry_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_HEAD = 2'd2
    } wr_sel_t;

endpackage

// File: rtl/defines.vh
// Shared datapath widths for the writeback / register-file interface.
`ifndef WB_DEFINES_VH
`define WB_DEFINES_VH

`define W_REGF    5
`define W_DATA    32
`define REGF_ZERO {`W_REGF{1'b0}}

`endif

// File: rtl/wb_pend_queue.sv
// In-order queue of late results. Entries stay packed from slot 0 (head);
// any entry may be removed by register match and the survivors compact.
`include "defines.vh"

module wb_pend_queue
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  pend_entry_t      enq_entry,
    input  logic             deq,
    input  logic             rm_en,
    input  regf_t            rm_regf,
    input  regf_t            query_regf,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output pend_entry_t      head_entry,
    output logic             head_removed,
    output logic [DEPTH-1:0] match_vec
);

    pend_entry_t      entry_reg  [DEPTH];
    pend_entry_t      entry_next [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] rm_hit;
    logic [DEPTH-1:0] keep;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign match_vec[gi] = valid_reg[gi] && (entry_reg[gi].regf == query_regf);
            assign rm_hit[gi]    = rm_en && valid_reg[gi] && (entry_reg[gi].regf == rm_regf);
            if (gi == 0) begin : g_head
                // The head additionally leaves when it is handed to the write port.
                assign keep[gi] = valid_reg[gi] && !rm_hit[gi] && !deq;
            end else begin : g_body
                assign keep[gi] = valid_reg[gi] && !rm_hit[gi];
            end
        end
    endgenerate

    assign head_valid   = valid_reg[0];
    assign head_entry   = entry_reg[0];
    assign head_removed = rm_hit[0];

    // Occupancy is the population count of the packed valid bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(valid_reg[i]);
        end
    end

    // Compact surviving entries toward the head, then append the new arrival.
    always_comb begin
        int slot;
        entry_next = entry_reg;
        valid_next = '0;
        slot       = 0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (keep[i] && (slot == j)) begin
                    entry_next[j] = entry_reg[i];
                    valid_next[j] = 1'b1;
                end
            end
            if (keep[i]) begin
                slot = slot + 1;
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (enq && (slot == j)) begin
                entry_next[j] = enq_entry;
                valid_next[j] = 1'b1;
            end
        end
    end

    // Valid bits are the only state that must clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Entry payloads follow the compaction network.
    always_ff @(posedge clk) begin
        entry_reg <= entry_next;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB-stage result and queued
// late results. WB normally wins; an aging guard stalls WB so the queue
// head cannot starve. The chosen write is registered onto the rf_* port.
`include "defines.vh"

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_we,
    input  logic [`W_REGF-1:0] pipe_regf,
    input  logic [`W_DATA-1:0] pipe_data,
    input  logic               late_valid,
    input  logic [`W_REGF-1:0] late_regf,
    input  logic [`W_DATA-1:0] late_data,
    output logic               late_ready,
    output logic               wb_stall,
    input  logic [`W_REGF-1:0] query_regf,
    output logic               query_hit,
    output logic               rf_we,
    output logic [`W_REGF-1:0] rf_waddr,
    output logic [`W_DATA-1:0] rf_wdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]    q_count;
    logic             head_valid;
    pend_entry_t      head_entry;
    logic             head_removed;
    logic [DEPTH-1:0] match_vec;

    logic             starve;
    logic             pipe_valid;
    logic             late_accept;
    logic             enq;
    logic             deq;
    logic             rm_en;
    pend_entry_t      late_entry;
    wr_sel_t          sel;

    logic [AW-1:0]    age_reg;
    logic [AW-1:0]    age_next;
    logic             rf_we_reg;
    logic             rf_we_next;
    regf_t            rf_waddr_reg;
    regf_t            rf_waddr_next;
    data_t            rf_wdata_reg;
    data_t            rf_wdata_next;

    // Acceptance depends only on occupancy; a same-cycle dequeue does not free a slot.
    assign late_ready  = (q_count < CW'(DEPTH));
    assign late_accept = late_valid && late_ready;

    assign starve     = head_valid && (age_reg >= AW'(STARVE_LIMIT));
    assign pipe_valid = pipe_we && (pipe_regf != REGF_ZERO);
    assign wb_stall   = starve;

    // Priority: starving head, then WB, then any queued head.
    always_comb begin
        sel = SEL_NONE;
        if (starve) begin
            sel = SEL_HEAD;
        end else if (pipe_valid) begin
            sel = SEL_PIPE;
        end else if (head_valid) begin
            sel = SEL_HEAD;
        end
    end

    assign deq   = (sel == SEL_HEAD);
    assign rm_en = (sel == SEL_PIPE);

    // R0 results and results already overwritten by the winning WB write are
    // acknowledged but never stored.
    assign enq = late_accept
              && (late_regf != REGF_ZERO)
              && !(rm_en && (late_regf == pipe_regf));

    assign late_entry.regf = late_regf;
    assign late_entry.data = late_data;

    assign query_hit = (query_regf != REGF_ZERO) && (|match_vec);

    wb_pend_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .enq          (enq),
        .enq_entry    (late_entry),
        .deq          (deq),
        .rm_en        (rm_en),
        .rm_regf      (pipe_regf),
        .query_regf   (query_regf),
        .count        (q_count),
        .head_valid   (head_valid),
        .head_entry   (head_entry),
        .head_removed (head_removed),
        .match_vec    (match_vec)
    );

    // Route the winner toward the write-port register.
    always_comb begin
        rf_we_next    = 1'b0;
        rf_waddr_next = REGF_ZERO;
        rf_wdata_next = '0;
        case (sel)
            SEL_PIPE: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = pipe_regf;
                rf_wdata_next = pipe_data;
            end
            SEL_HEAD: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = head_entry.regf;
                rf_wdata_next = head_entry.data;
            end
            default: begin
            end
        endcase
    end

    // Age tracks how long the current head has been losing to WB.
    always_comb begin
        age_next = age_reg;
        if (!head_valid || deq || head_removed) begin
            age_next = '0;
        end else if (age_reg < AW'(STARVE_LIMIT)) begin
            age_next = age_reg + AW'(1);
        end
    end

    // Registered write port and aging state.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_reg      <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= REGF_ZERO;
            rf_wdata_reg <= '0;
        end else begin
            age_reg      <= age_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we;
    logic [4:0]  pipe_regf;
    logic [31:0] pipe_data;
    logic        late_valid;
    logic [4:0]  late_regf;
    logic [31:0] late_data;
    logic        late_ready;
    logic        wb_stall;
    logic [4:0]  query_regf;
    logic        query_hit;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_regf  (pipe_regf),
        .pipe_data  (pipe_data),
        .late_valid (late_valid),
        .late_regf  (late_regf),
        .late_data  (late_data),
        .late_ready (late_ready),
        .wb_stall   (wb_stall),
        .query_regf (query_regf),
        .query_hit  (query_hit),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    typedef struct {
        logic [4:0]  regf;
        logic [31:0] data;
    } ent_t;

    // Reference model state.
    ent_t        mq[$];
    int          age = 0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_waddr = 5'd0;
    logic [31:0] exp_wdata = 32'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, req);
        end
    endtask

    task automatic set_pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
        pipe_we   = we;
        pipe_regf = r;
        pipe_data = d;
    endtask

    task automatic set_late(input logic v, input logic [4:0] r, input logic [31:0] d);
        late_valid = v;
        late_regf  = r;
        late_data  = d;
    endtask

    // Called just after a falling edge with inputs already driven: compare
    // outputs with the model, advance the model, then move to the next cycle.
    task automatic tick();
        logic exp_ready;
        logic exp_starve;
        logic exp_hit;
        logic pipe_won;
        logic start_empty;
        logic head_gone;
        ent_t e;
        #1;
        exp_ready  = (mq.size() < DEPTH);
        exp_starve = (mq.size() > 0) && (age >= LIMIT);
        exp_hit    = 1'b0;
        if (query_regf != 5'd0) begin
            foreach (mq[k]) if (mq[k].regf == query_regf) exp_hit = 1'b1;
        end
        check("late_ready", {31'd0, late_ready}, {31'd0, exp_ready});
        check("wb_stall",   {31'd0, wb_stall},   {31'd0, exp_starve});
        check("query_hit",  {31'd0, query_hit},  {31'd0, exp_hit});
        check("rf_we",      {31'd0, rf_we},      {31'd0, exp_we});
        if (exp_we) begin
            check("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_waddr});
            check("rf_wdata", rf_wdata, exp_wdata);
        end
        $display("cyc=%0d rst=%0b pipe=%0b/%0d late=%0b/%0d rdy=%0b stall=%0b rf=%0b/%0d/%0h qlen=%0d",
                 cyc, rst, pipe_we, pipe_regf, late_valid, late_regf, late_ready, wb_stall,
                 rf_we, rf_waddr, rf_wdata, mq.size());

        if (rst) begin
            mq.delete();
            age    = 0;
            exp_we = 1'b0;
        end else begin
            start_empty = (mq.size() == 0);
            pipe_won    = 1'b0;
            head_gone   = 1'b0;
            exp_we      = 1'b0;
            if (exp_starve) begin
                exp_we    = 1'b1;
                exp_waddr = mq[0].regf;
                exp_wdata = mq[0].data;
                void'(mq.pop_front());
                head_gone = 1'b1;
            end else if (pipe_we && pipe_regf != 5'd0) begin
                pipe_won  = 1'b1;
                exp_we    = 1'b1;
                exp_waddr = pipe_regf;
                exp_wdata = pipe_data;
                if (!start_empty && mq[0].regf == pipe_regf) head_gone = 1'b1;
                for (int k = mq.size() - 1; k >= 0; k--) begin
                    if (mq[k].regf == pipe_regf) mq.delete(k);
                end
            end else if (!start_empty) begin
                exp_we    = 1'b1;
                exp_waddr = mq[0].regf;
                exp_wdata = mq[0].data;
                void'(mq.pop_front());
                head_gone = 1'b1;
            end
            if (start_empty || head_gone) age = 0;
            else if (age < LIMIT) age = age + 1;
            if (late_valid && exp_ready && late_regf != 5'd0
                && !(pipe_won && late_regf == pipe_regf)) begin
                e.regf = late_regf;
                e.data = late_data;
                mq.push_back(e);
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_pipe(1'b0, 5'd0, 32'd0);
        set_late(1'b0, 5'd0, 32'd0);
        query_regf = 5'd0;
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Plain WB write.
        set_pipe(1'b1, 5'd8, 32'h11);
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();

        // Late result on an idle pipeline, with a query on its register.
        set_late(1'b1, 5'd9, 32'hAA);
        query_regf = 5'd9;
        tick();
        set_late(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        tick();

        // Starvation: WB hammering r3 while r5 waits.
        set_pipe(1'b1, 5'd3, 32'h33);
        set_late(1'b1, 5'd5, 32'h55);
        query_regf = 5'd5;
        tick();
        set_late(1'b0, 5'd0, 32'd0);
        repeat (7) tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        tick();
        tick();

        // Supersession: queue {7,12}, then WB writes r7.
        set_pipe(1'b1, 5'd20, 32'h2020);
        set_late(1'b1, 5'd7, 32'h77);
        query_regf = 5'd7;
        tick();
        set_late(1'b1, 5'd12, 32'h1212);
        tick();
        set_late(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd7, 32'h7777);
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        query_regf = 5'd12;
        repeat (3) tick();

        // Full queue backpressure, then R0 traffic from both sides.
        set_pipe(1'b1, 5'd20, 32'h2121);
        set_late(1'b1, 5'd10, 32'h1010);
        tick();
        set_late(1'b1, 5'd11, 32'h1111);
        tick();
        set_late(1'b1, 5'd13, 32'h1313);
        repeat (7) tick();
        set_late(1'b1, 5'd0, 32'hDEAD);
        set_pipe(1'b1, 5'd0, 32'hBEEF);
        query_regf = 5'd0;
        tick();
        set_late(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        repeat (5) tick();

        // Reset with two queued entries and age 3.
        set_pipe(1'b1, 5'd20, 32'h2222);
        set_late(1'b1, 5'd14, 32'h1414);
        tick();
        set_late(1'b1, 5'd15, 32'h1515);
        tick();
        set_late(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        query_regf = 5'd14;
        tick();
        query_regf = 5'd15;
        tick();

        // Random traffic over a small register range to force collisions.
        repeat (400) begin
            rst = ($urandom_range(0, 99) == 0);
            set_pipe(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
            set_late(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            query_regf = 5'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_late(1'b0, 5'd0, 32'd0);
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
